// File: rtl/relu_stream.sv
// Streaming elementwise ReLU with optional upper clamp, feeding a registered 2-entry output buffer.
// The buffer is a head/tail register pair, so in_rdy depends only on flops.
module relu_stream #(
    parameter int              WIDTH     = 16,
    parameter int              FRAC      = 8,
    parameter int              CLAMP_EN  = 0,
    parameter logic [WIDTH-1:0] CLAMP_MAX = 'h0600,
    parameter int              CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] neg_cnt
);

    if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
        $error("relu_stream: FRAC must lie in [0, WIDTH)");
    end

    logic             out_val_q, out_val_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             tail_val_q, tail_val_d;
    logic [WIDTH-1:0] tail_data_q, tail_data_d;
    logic             in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0] neg_cnt_q, neg_cnt_d;

    logic             push;
    logic             pop;
    logic             in_neg;
    logic [WIDTH-1:0] act;

    assign push   = in_val && in_rdy_q;
    assign pop    = out_val_q && out_rdy;
    assign in_neg = in_data[WIDTH-1];

    always_comb begin
        act = in_neg ? '0 : in_data;
        if (CLAMP_EN != 0 && !in_neg && $signed(in_data) > $signed(CLAMP_MAX)) begin
            act = CLAMP_MAX;
        end
    end

    always_comb begin
        out_val_d   = out_val_q;
        out_data_d  = out_data_q;
        tail_val_d  = tail_val_q;
        tail_data_d = tail_data_q;
        neg_cnt_d   = neg_cnt_q;

        if (out_val_q && !pop) begin
            // Head is stalled; a push can only land in the tail since in_rdy implies not full.
            if (push) begin
                tail_val_d  = 1'b1;
                tail_data_d = act;
            end
        end else begin
            if (tail_val_q) begin
                out_val_d  = 1'b1;
                out_data_d = tail_data_q;
                tail_val_d = push;
                if (push) begin
                    tail_data_d = act;
                end
            end else if (push) begin
                out_val_d  = 1'b1;
                out_data_d = act;
            end else begin
                out_val_d = 1'b0;
            end
        end

        in_rdy_d = !(out_val_d && tail_val_d);

        if (push && in_neg && !(&neg_cnt_q)) begin
            neg_cnt_d = neg_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_val_q   <= 1'b0;
            out_data_q  <= '0;
            tail_val_q  <= 1'b0;
            tail_data_q <= '0;
            in_rdy_q    <= 1'b0;
            neg_cnt_q   <= '0;
        end else begin
            out_val_q   <= out_val_d;
            out_data_q  <= out_data_d;
            tail_val_q  <= tail_val_d;
            tail_data_q <= tail_data_d;
            in_rdy_q    <= in_rdy_d;
            neg_cnt_q   <= neg_cnt_d;
        end
    end

    assign in_rdy   = in_rdy_q;
    assign out_val  = out_val_q;
    assign out_data = out_data_q;
    assign neg_cnt  = neg_cnt_q;

endmodule

// File: tb/tb_relu_stream.sv
// Directed and random checks of relu_stream: a plain instance and a clamped
// instance with a narrow counter share one stimulus stream.
module tb_relu_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_val;
    logic [15:0] in_data;
    logic        out_rdy;

    logic        in_rdy0, out_val0;
    logic [15:0] out_data0;
    logic [31:0] neg_cnt0;
    logic        in_rdy1, out_val1;
    logic [15:0] out_data1;
    logic [2:0]  neg_cnt1;

    int checks = 0;
    int errors = 0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;

    relu_stream dut0 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy0), .in_data(in_data),
        .out_val(out_val0), .out_rdy(out_rdy), .out_data(out_data0), .neg_cnt(neg_cnt0)
    );

    relu_stream #(.CLAMP_EN(1), .CLAMP_MAX(16'h0600), .CNT_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_val(in_val), .in_rdy(in_rdy1), .in_data(in_data),
        .out_val(out_val1), .out_rdy(out_rdy), .out_data(out_data1), .neg_cnt(neg_cnt1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] relu_ref(input logic [15:0] x);
        return x[15] ? 16'h0000 : x;
    endfunction

    function automatic logic [15:0] relu6_ref(input logic [15:0] x);
        if (x[15]) return 16'h0000;
        if (x > 16'h0600) return 16'h0600;
        return x;
    endfunction

    // Scoreboards: an output transfer happens at the posedge following this sample point.
    always @(negedge clk) begin
        #1;
        if (rst && out_rdy && out_val0) begin
            if (q0.size() == 0) check("unexpected_out0", {16'h0, out_data0}, 32'hFFFF_FFFF);
            else check("out0", {16'h0, out_data0}, {16'h0, q0.pop_front()});
        end
        if (rst && out_rdy && out_val1) begin
            if (q1.size() == 0) check("unexpected_out1", {16'h0, out_data1}, 32'hFFFF_FFFF);
            else check("out1", {16'h0, out_data1}, {16'h0, q1.pop_front()});
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [15:0] d);
        int n = 0;
        in_val  = 1'b1;
        in_data = d;
        while (!in_rdy0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy0) check("send_timeout", 32'(n), 32'd0);
        @(negedge clk);
        in_val = 1'b0;
    endtask

    task automatic expect2(input logic [15:0] e0, input logic [15:0] e1);
        q0.push_back(e0);
        q1.push_back(e1);
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(q0.size() + q1.size()), 32'd0);
    endtask

    logic [15:0] bnd_in [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF, 16'h0001};
    logic [15:0] bnd_e0 [5] = '{16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0001};
    logic [15:0] bnd_e1 [5] = '{16'h0000, 16'h0600, 16'h0000, 16'h0000, 16'h0001};
    logic [15:0] clp_in [4] = '{16'h0700, 16'h0600, 16'h05FF, 16'hF000};
    logic [15:0] clp_e0 [4] = '{16'h0700, 16'h0600, 16'h05FF, 16'h0000};
    logic [15:0] clp_e1 [4] = '{16'h0600, 16'h0600, 16'h05FF, 16'h0000};

    int  negs;
    bit  rnd_done;
    logic [15:0] d;

    initial begin
        rst = 1'b0; in_val = 1'b0; in_data = 16'h0; out_rdy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_val", {31'h0, out_val0}, 32'd0);
        check("rst_out_data", {16'h0, out_data0}, 32'd0);
        check("rst_neg_cnt", neg_cnt0, 32'd0);
        check("rst_in_rdy", {31'h0, in_rdy0}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_exit_in_rdy", {31'h0, in_rdy0}, 32'd1);

        // Basic: one-cycle latency, back to back
        out_rdy = 1'b1;
        expect2(16'h0100, 16'h0100);
        expect2(16'h0000, 16'h0000);
        send(16'h0100);
        check("lat_val0", {31'h0, out_val0}, 32'd1);
        check("lat_data0", {16'h0, out_data0}, 32'h0100);
        send(16'hFF00);
        check("lat_val1", {31'h0, out_val0}, 32'd1);
        check("lat_data1", {16'h0, out_data0}, 32'h0000);
        drain();
        check("basic_neg_cnt", neg_cnt0, 32'd1);

        for (int i = 0; i < 5; i++) begin
            expect2(bnd_e0[i], bnd_e1[i]);
            send(bnd_in[i]);
        end
        drain();
        check("bnd_neg_cnt", neg_cnt0, 32'd3);

        // Backpressure: two held, third waits
        out_rdy = 1'b0;
        expect2(16'h0200, 16'h0200);
        expect2(16'h0300, 16'h0300);
        expect2(16'h0400, 16'h0400);
        send(16'h0200);
        send(16'h0300);
        check("bp_in_rdy", {31'h0, in_rdy0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_val", {31'h0, out_val0}, 32'd1);
            check("bp_hold_data", {16'h0, out_data0}, 32'h0200);
            @(negedge clk);
        end
        fork
            send(16'h0400);
            begin
                repeat (2) @(negedge clk);
                out_rdy = 1'b1;
            end
        join
        drain();

        for (int i = 0; i < 4; i++) begin
            expect2(clp_e0[i], clp_e1[i]);
            send(clp_in[i]);
        end
        drain();
        check("clamp_neg_cnt0", neg_cnt0, 32'd4);
        check("clamp_neg_cnt1", {29'h0, neg_cnt1}, 32'd4);

        // Reset while two items are buffered
        out_rdy = 1'b0;
        send(16'h0A00);
        send(16'h8001);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_val", {31'h0, out_val0}, 32'd0);
        check("mid_rst_neg_cnt", neg_cnt0, 32'd0);
        check("mid_rst_in_rdy", {31'h0, in_rdy0}, 32'd0);
        rst = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        check("mid_rst_exit_in_rdy", {31'h0, in_rdy0}, 32'd1);
        repeat (3) @(negedge clk);
        check("mid_rst_no_stale", {31'h0, out_val0}, 32'd0);
        expect2(16'h0123, 16'h0123);
        send(16'h0123);
        drain();

        // Random traffic
        negs = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    d = 16'($urandom_range(0, 65535));
                    expect2(relu_ref(d), relu6_ref(d));
                    if (d[15]) negs++;
                    if ($urandom_range(0, 3) == 0) @(negedge clk);
                    send(d);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    if (!rnd_done) out_rdy = 1'($urandom_range(0, 1));
                end
            end
        join
        @(negedge clk);
        out_rdy = 1'b1;
        drain();
        check("rnd_neg_cnt0", neg_cnt0, 32'(negs));
        check("rnd_neg_cnt1_sat", {29'h0, neg_cnt1}, (negs > 7) ? 32'd7 : 32'(negs));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
